multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Sequencing controller for the multicycle version of the processor datapath. It walks each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables and mux selects using the same op/funct5/funct0 instruction classes as the single-cycle main decoder. It sits between the instruction register and the datapath, and stalls on a memory ready handshake.

Parameters:
FETCH_PC_INC, 2, alusrcb select code that routes the constant 4 during FETCH/DECODE
ILLEGAL_TRAP, 0, 1 = stay in ILLEGAL state on op==2'b11; 0 = pulse illegal and return to FETCH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  2  instruction class from IR: 00 data-proc, 01 memory, 10 branch, 11 illegal
funct5  in  1  immediate bit (1 = immediate operand)
funct0  in  1  load bit (1 = LDR, 0 = STR)
cond_ex  in  1  condition-check result; gates architectural writes
mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
pcwrite  out  1  PC load enable
irwrite  out  1  IR load enable
adrsrc  out  1  memory address: 0 = PC, 1 = ALU result register
memw  out  1  memory write enable
regw  out  1  register file write enable
alusrca  out  1  ALU A: 0 = register, 1 = PC
alusrcb  out  2  ALU B: 00 register, 01 extended immediate, 10 constant 4
immsrc  out  2  extender: 00 data-proc imm, 01 memory offset, 10 branch offset
regsrc  out  2  register read select: 00 normal, 01 branch, 10 store
resultsrc  out  2  result mux: 00 ALUOut, 01 read data, 10 ALU direct
aluop  out  1  1 = ALU decoder uses funct; 0 = force add
branch  out  1  high during BRANCH
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  high while in ILLEGAL, or a one-cycle pulse (per ILLEGAL_TRAP)

Behaviour:
- State encoding: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, ILLEGAL. Registered state; outputs are combinational from state, gated by mem_ready/cond_ex as noted.
- Reset (rst_n=0, async): state=FETCH. pcwrite, irwrite, memw, regw, instr_done, illegal are forced to 0 while rst_n=0. Selects take FETCH values: adrsrc=0, alusrca=1, alusrcb=10, resultsrc=10, aluop=0, branch=0, immsrc=00, regsrc=00.
- FETCH: adrsrc=0, alusrca=1, alusrcb=10, resultsrc=10, aluop=0. Hold while mem_ready=0. In the mem_ready=1 cycle: irwrite=1, pcwrite=1, then go to DECODE.
- DECODE: alusrca=1, alusrcb=10 (PC+8). Next state:
  - op 00, funct5 0 → EXECR
  - op 00, funct5 1 → EXECI
  - op 01 → MEMADR
  - op 10 → BRANCH
  - op 11 → ILLEGAL
- MEMADR: alusrca=0, alusrcb=01, immsrc=01, aluop=0. funct0=1 → MEMRD, else → MEMWR.
- MEMRD: adrsrc=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: resultsrc=01, regw=cond_ex, instr_done=1, then go to FETCH.
- MEMWR: adrsrc=1, regsrc=10, memw=cond_ex, held for every wait cycle. Leave on mem_ready=1 with instr_done=1, then go to FETCH. When cond_ex=0, no wait: go to FETCH next cycle.
- EXECR: alusrca=0, alusrcb=00, aluop=1, then go to ALUWB.
- EXECI: alusrca=0, alusrcb=01, immsrc=00, aluop=1, then go to ALUWB.
- ALUWB: resultsrc=00, regw=cond_ex, instr_done=1, then go to FETCH.
- BRANCH: alusrca=0, alusrcb=01, immsrc=10, regsrc=01, resultsrc=10, branch=1, pcwrite=cond_ex, instr_done=1, then go to FETCH.
- ILLEGAL: all strobes 0, illegal=1. ILLEGAL_TRAP=1: stay until reset. ILLEGAL_TRAP=0: one cycle, then go to FETCH.
- Latency with mem_ready tied to 1:
  - data-proc: 4 cycles
  - branch: 3 cycles
  - store: 4 cycles
  - load: 5 cycles
- Reset mid-operation (including during a memory wait) aborts immediately; no strobe glitches high.
- Unlisted selects default to 0 in every state; no latches. Unknown state encoding recovers to FETCH.

Decomposition:
- Shared package ctrl_pkg: state enum, and localparams for the alusrcb, immsrc, regsrc and resultsrc codes. The single-cycle decoder reuses these.
- Sub-module: none needed; one next-state always_comb, one output always_comb, one async-reset state flop.

Test Plan:
- Reset sequence: hold rst_n=0 mid-MEMRD, release → state FETCH, pcwrite=irwrite=0 during reset; first mem_ready=1 cycle gives irwrite=pcwrite=1.
- op=00, funct5=1, cond_ex=1, mem_ready=1 → FETCH, DECODE, EXECI (alusrcb=01, immsrc=00, aluop=1), ALUWB (regw=1, resultsrc=00); instr_done on cycle 4.
- op=01, funct0=1, mem_ready low for 3 cycles in MEMRD → adrsrc=1 held 4 cycles; MEMWB resultsrc=01, regw=1; total 8 cycles.
- op=01, funct0=0, cond_ex=1, mem_ready=0 for 2 cycles → memw=1 for 3 consecutive cycles, regsrc=10; with cond_ex=0 → memw never asserts.
- op=10, cond_ex=0 → BRANCH has branch=1, immsrc=10, pcwrite=0; with cond_ex=1 → pcwrite=1; back in FETCH next cycle.
- op=11 → ILLEGAL_TRAP=0: illegal pulses 1 cycle then FETCH; ILLEGAL_TRAP=1: illegal stays high, no strobes, until rst_n low.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding and datapath select codes shared by the control decoders
package ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, ILLEGAL
    } state_t;
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;
    localparam logic [1:0] REG_NORM = 2'b00;
    localparam logic [1:0] REG_BR   = 2'b01;
    localparam logic [1:0] REG_STR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences each instruction through fetch/decode/execute/memory/writeback
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter logic [1:0] FETCH_PC_INC = ALUB_FOUR,
    parameter bit         ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic       funct5,
    input  logic       funct0,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       adrsrc,
    output logic       memw,
    output logic       regw,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [1:0] resultsrc,
    output logic       aluop,
    output logic       branch,
    output logic       instr_done,
    output logic       illegal
);
    state_t state, next;

    // state register, reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FETCH;
        else        state <= next;

    // next-state; undefined encodings fall back to FETCH
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:   next = mem_ready ? DECODE : FETCH;
            DECODE:  next = op == OP_DP  ? (funct5 ? EXECI : EXECR) :
                            op == OP_MEM ? MEMADR :
                            op == OP_BR  ? BRANCH : ILLEGAL;
            MEMADR:  next = funct0 ? MEMRD : MEMWR;
            MEMRD:   next = mem_ready ? MEMWB : MEMRD;
            MEMWR:   next = (mem_ready || !cond_ex) ? FETCH : MEMWR;
            EXECR:   next = ALUWB;
            EXECI:   next = ALUWB;
            ILLEGAL: next = ILLEGAL_TRAP ? ILLEGAL : FETCH;
            default: next = FETCH;
        endcase
    end

    // datapath controls; strobes are held low for the whole reset interval
    always_comb begin
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        adrsrc     = 1'b0;
        memw       = 1'b0;
        regw       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUB_REG;
        immsrc     = IMM_DP;
        regsrc     = REG_NORM;
        resultsrc  = RES_ALUOUT;
        aluop      = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = FETCH_PC_INC;
                resultsrc = RES_ALU;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            DECODE: begin
                alusrca = 1'b1;
                alusrcb = FETCH_PC_INC;
            end
            MEMADR: begin
                alusrcb = ALUB_IMM;
                immsrc  = IMM_MEM;
            end
            MEMRD: adrsrc = 1'b1;
            MEMWB: begin
                resultsrc  = RES_RDATA;
                regw       = cond_ex;
                instr_done = 1'b1;
            end
            MEMWR: begin
                adrsrc     = 1'b1;
                regsrc     = REG_STR;
                memw       = cond_ex;
                instr_done = mem_ready | ~cond_ex;
            end
            EXECR: aluop = 1'b1;
            EXECI: begin
                alusrcb = ALUB_IMM;
                aluop   = 1'b1;
            end
            ALUWB: begin
                regw       = cond_ex;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alusrcb    = ALUB_IMM;
                immsrc     = IMM_BR;
                regsrc     = REG_BR;
                resultsrc  = RES_ALU;
                branch     = 1'b1;
                pcwrite    = cond_ex;
                instr_done = 1'b1;
            end
            ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            memw       = 1'b0;
            regw       = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: random and directed checking of both illegal-op policies against a model
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] op = 2'b00;
    logic funct5 = 1'b0, funct0 = 1'b0, cond_ex = 1'b0, mem_ready = 1'b0;
    logic [1:0] pcwrite, irwrite, adrsrc, memw, regw, alusrca, aluop, branch, instr_done, illegal;
    logic [1:0][1:0] alusrcb, immsrc, regsrc, resultsrc;
    int n_checks = 0;
    int n_fail = 0;
    int pos[2];
    int kd[2];
    logic kf[2];

    always #5 clk = ~clk;

    // instance 0 returns from an illegal op, instance 1 traps on it
    for (genvar g = 0; g < 2; g++) begin : dut_g
        multicycle_control_fsm #(.FETCH_PC_INC(2'b10), .ILLEGAL_TRAP(g == 1)) u (
            .clk(clk), .rst_n(rst_n), .op(op), .funct5(funct5), .funct0(funct0),
            .cond_ex(cond_ex), .mem_ready(mem_ready),
            .pcwrite(pcwrite[g]), .irwrite(irwrite[g]), .adrsrc(adrsrc[g]), .memw(memw[g]),
            .regw(regw[g]), .alusrca(alusrca[g]), .alusrcb(alusrcb[g]), .immsrc(immsrc[g]),
            .regsrc(regsrc[g]), .resultsrc(resultsrc[g]), .aluop(aluop[g]), .branch(branch[g]),
            .instr_done(instr_done[g]), .illegal(illegal[g])
        );
    end

    // instruction kinds: 0 data-proc, 1 load, 2 store, 3 branch, 4 illegal
    function automatic int kind_of(input logic [1:0] o, input logic f0);
        return o == 2'b00 ? 0 : o == 2'b01 ? (f0 ? 1 : 2) : o == 2'b10 ? 3 : 4;
    endfunction

    function automatic int len_of(input int k);
        return k == 1 ? 5 : (k == 0 || k == 2) ? 4 : 3;
    endfunction

    // expected controls from instruction kind and cycle position within the instruction
    function automatic logic [17:0] expv(input int k, input int p, input logic f5,
                                         input logic mr, input logic ce, input logic rn);
        logic pw, iw, as, mw, rw, aa, ao, br, dn, il;
        logic [1:0] ab, im, rs, rr;
        {pw, iw, as, mw, rw, aa, ao, br, dn, il} = '0;
        {ab, im, rs, rr} = '0;
        if (!rn) p = 0;
        if (p == 0) begin
            aa = 1; ab = 2; rr = 2; pw = mr; iw = mr;
        end else if (p == 1) begin
            aa = 1; ab = 2;
        end else if (k == 0) begin
            if (p == 2) begin ab = f5 ? 2'd1 : 2'd0; ao = 1; end
            else begin rw = ce; dn = 1; end
        end else if (k == 1 || k == 2) begin
            if (p == 2) begin ab = 1; im = 1; end
            else if (p == 3 && k == 1) as = 1;
            else if (p == 3) begin as = 1; rs = 2; mw = ce; dn = mr | ~ce; end
            else begin rr = 1; rw = ce; dn = 1; end
        end else if (k == 3) begin
            ab = 1; im = 2; rs = 1; rr = 2; br = 1; pw = ce; dn = 1;
        end else il = 1;
        if (!rn) {pw, iw, mw, rw, dn, il} = '0;
        return {pw, iw, as, mw, rw, aa, ab, im, rs, rr, ao, br, dn, il};
    endfunction

    // reference model: advance each instance's position at the clock edge
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) pos[m] = 0;
            else begin
                if (pos[m] == 1) begin kd[m] = kind_of(op, funct0); kf[m] = funct5; end
                if (!((pos[m] == 0 && !mem_ready) ||
                      (kd[m] == 1 && pos[m] == 3 && !mem_ready) ||
                      (kd[m] == 2 && pos[m] == 3 && cond_ex && !mem_ready) ||
                      (kd[m] == 4 && pos[m] == 2 && m == 1)))
                    pos[m] = (pos[m] == len_of(kd[m]) - 1) ? 0 : pos[m] + 1;
            end
        end
    end

    // compare every cycle mid-period
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [17:0] e, a;
            e = expv(kd[m], pos[m], kf[m], mem_ready, cond_ex, rst_n);
            a = {pcwrite[m], irwrite[m], adrsrc[m], memw[m], regw[m], alusrca[m], alusrcb[m],
                 immsrc[m], regsrc[m], resultsrc[m], aluop[m], branch[m], instr_done[m], illegal[m]};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ctrl[%0d] t=%0t got %h expected %h", m, $time, a, e);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // one instruction from FETCH, stalling memory accesses for 'waits' cycles
    task automatic run(input logic [1:0] o, input logic f5i, input logic f0i, input logic cei,
                       input int waits, output int cyc, output int nmw, output int nas, output int npw);
        int w = 0;
        op = o; funct5 = f5i; funct0 = f0i; cond_ex = cei;
        cyc = 0; nmw = 0; nas = 0; npw = 0;
        for (int i = 0; i < 40; i++) begin
            mem_ready = !(adrsrc[0] && w < waits);
            if (adrsrc[0] && w < waits) w++;
            @(negedge clk);
            cyc++; nmw += memw[0]; nas += adrsrc[0]; npw += pcwrite[0];
            if (instr_done[0]) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int c, mw, as, pw, i0, i1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        op = 2'b01; funct0 = 1'b1; cond_ex = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 10 && !adrsrc[0]; i++) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_irwrite", irwrite[0], 0);
        chk("rst_pcwrite", pcwrite[0], 0);
        chk("rst_adrsrc", adrsrc[0], 0);
        @(posedge clk); #3 rst_n = 1'b1; op = 2'b00; funct5 = 1'b0;
        @(negedge clk);
        chk("rel_irwrite", irwrite[0], 1);
        chk("rel_pcwrite", pcwrite[0], 1);
        @(posedge clk); #1;
        run(2'b00, 1'b0, 1'b0, 1'b1, 0, c, mw, as, pw); chk("post_rst_cycles", c, 3);
        run(2'b00, 1'b1, 1'b0, 1'b1, 0, c, mw, as, pw); chk("dpi_cycles", c, 4);
        run(2'b00, 1'b0, 1'b0, 1'b0, 0, c, mw, as, pw); chk("dpr_cycles", c, 4);
        run(2'b01, 1'b0, 1'b1, 1'b1, 3, c, mw, as, pw); chk("ldr_cycles", c, 8); chk("ldr_adrsrc", as, 4);
        run(2'b01, 1'b0, 1'b1, 1'b1, 0, c, mw, as, pw); chk("ldr_fast_cycles", c, 5);
        run(2'b01, 1'b0, 1'b0, 1'b1, 2, c, mw, as, pw); chk("str_cycles", c, 6); chk("str_memw", mw, 3);
        run(2'b01, 1'b0, 1'b0, 1'b0, 2, c, mw, as, pw); chk("str_nc_cycles", c, 4); chk("str_nc_memw", mw, 0);
        run(2'b10, 1'b0, 1'b0, 1'b0, 0, c, mw, as, pw); chk("b_nc_cycles", c, 3); chk("b_nc_pcwrite", pw, 1);
        run(2'b10, 1'b0, 1'b0, 1'b1, 0, c, mw, as, pw); chk("b_cycles", c, 3); chk("b_pcwrite", pw, 2);
        op = 2'b11; i0 = 0; i1 = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin op = 2'b00; funct5 = 1'b0; end
            mem_ready = 1'b1;
            @(negedge clk);
            i0 += illegal[0]; i1 += illegal[1];
            @(posedge clk); #1;
        end
        chk("ill_pulse", i0, 1);
        chk("ill_trap", i1, 5);
        #2 rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("trap_rst_illegal", illegal[1], 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3000; i++) begin
            if (pos[0] == 0) begin
                op = 2'($urandom); funct5 = 1'($urandom); funct0 = 1'($urandom);
            end
            mem_ready = ($urandom % 5) != 0;
            cond_ex = 1'($urandom);
            if ($urandom % 50 == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk); #3 rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
